uart_ibus_bridge: RTL and testbench
===================================

UART_IBUS_BRIDGE -- requirements
Module: uart_ibus_bridge

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, clk cycles per UART bit (minimum 4).
REQ-002 SHALL have parameter RD_LAT, default 1, cycles from ren pulse to valid ibus_rdata (range 1-7).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port rx, input, 1, UART receive line (8N1, idle high, asynchronous to clk).
REQ-006 SHALL have port tx, output, 1, UART transmit line (8N1, idle high).
REQ-007 SHALL have port ren, output, 1, one-cycle read strobe to the array bus.
REQ-008 SHALL have port ibus_radr, output, 16, read address, valid while ren=1.
REQ-009 SHALL have port ibus_rdata, input, 16, read data, sampled RD_LAT cycles after ren.
REQ-010 SHALL have port wen, output, 1, one-cycle write strobe.
REQ-011 SHALL have ports ibus_wadr and ibus_wdata, output, 16 each, valid while wen=1.
REQ-012 SHALL have port busy, output, 1, high whenever the command FSM is not in IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Receiver SHALL detect a start bit on a falling edge, re-check low at BAUD_DIV/2, sample each data bit at mid-bit, LSB first.
REQ-015 A stop bit sampled low SHALL be a framing error: byte discarded, command FSM forced to IDLE.
REQ-016 Command FSM states: IDLE, ADR_HI, ADR_LO, DAT_HI, DAT_LO, ISSUE_W, ISSUE_R, WAIT_R, TX_B0, TX_B1.
REQ-017 IDLE: byte 0x57 ('W') -> ADR_HI (write); 0x52 ('R') -> ADR_HI (read); any other byte ignored, stay IDLE.
REQ-018 ADR_HI/ADR_LO SHALL capture address bits [15:8]/[7:0]; after ADR_LO a write goes to DAT_HI, a read to ISSUE_R.
REQ-019 DAT_HI/DAT_LO SHALL capture data bits [15:8]/[7:0], then ISSUE_W.
REQ-020 ISSUE_W SHALL assert wen for exactly one cycle with ibus_wadr/ibus_wdata valid, then load ack byte 0x4B and go to TX_B1.
REQ-021 ISSUE_R SHALL assert ren for exactly one cycle with ibus_radr valid, then WAIT_R.
REQ-022 WAIT_R SHALL count RD_LAT cycles after the ren cycle, capture ibus_rdata on the last, then TX_B0.
REQ-023 TX_B0 SHALL send rdata[15:8], then TX_B1 sends rdata[7:0] (or the ack); after its stop bit completes -> IDLE.
REQ-024 Transmitter: 1 start, 8 data LSB first, 1 stop, each exactly BAUD_DIV cycles; tx=1 between frames.
REQ-025 Bytes received while in ISSUE_*, WAIT_R, TX_B0 or TX_B1 SHALL be dropped (half-duplex protocol).
REQ-026 ren and wen SHALL never be asserted in the same cycle; outside their strobe cycles they are 0.
REQ-027 Address/data outputs SHALL hold their last value between strobes.
REQ-028 Baud counters SHALL wrap to 0 at BAUD_DIV-1; no accumulated drift across a frame.

Reset
REQ-029 On rst_n=0, immediately: FSM=IDLE, tx=1, ren=0, wen=0, busy=0, ibus_radr/ibus_wadr/ibus_wdata=0, synchronizer flops=1, counters=0.
REQ-030 Reset asserted mid-frame or mid-transmit SHALL abort it; after release the block waits for a fresh start bit.

Structure
REQ-031 Opcodes 0x57, 0x52, ack 0x4B and FSM state encodings SHALL live in a shared package, bridge_pkg.
REQ-032 The bit-level receiver (synchronizer, start detect, sampling, framing check) SHALL be one sub-module, uart_rx_byte, emitting a 1-cycle byte_valid with 8-bit data and frame_err.
REQ-033 Transmitter and command FSM SHALL stay in uart_ibus_bridge.

Verification (BAUD_DIV=8, RD_LAT=1 unless stated)
REQ-034 Send 57 12 34 AB CD -> single wen cycle with wadr=0x1234, wdata=0xABCD; tx returns 0x4B.
REQ-035 Model returns 0xBEEF; send 52 00 10 -> single ren cycle, radr=0x0010; tx returns BE then EF.
REQ-036 RD_LAT=3, model data valid only on 3rd cycle after ren -> returned value matches that cycle's data.
REQ-037 Send 41 then 57 00 01 00 02 -> 0x41 ignored; write to 0x0001 data 0x0002, ack 0x4B.
REQ-038 Send 57 12 with stop bit of 0x12 forced low, then 52 00 00 -> no wen; read completes normally.
REQ-039 Assert rst_n low during DAT_LO reception -> tx=1, wen=0, busy=0 immediately; next full command succeeds.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared constants for the UART-to-ibus bridge: protocol bytes, command FSM
// encodings and receiver state encodings.
package bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h4B;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_ADR_HI  = 4'd1;
    localparam logic [3:0] ST_ADR_LO  = 4'd2;
    localparam logic [3:0] ST_DAT_HI  = 4'd3;
    localparam logic [3:0] ST_DAT_LO  = 4'd4;
    localparam logic [3:0] ST_ISSUE_W = 4'd5;
    localparam logic [3:0] ST_ISSUE_R = 4'd6;
    localparam logic [3:0] ST_WAIT_R  = 4'd7;
    localparam logic [3:0] ST_TX_B0   = 4'd8;
    localparam logic [3:0] ST_TX_B1   = 4'd9;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // 8N1 frame as shifted out LSB first: start(0), data LSB..MSB, stop(1).
    function automatic logic [9:0] uart_frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 receiver: synchronizes rx, finds the start bit, samples mid-bit
// and reports either a good byte or a framing error as a one-cycle pulse.
module uart_rx_byte
    import bridge_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2);

    logic [1:0]    sync;
    logic          rx_d;
    logic          rx_s;
    logic [1:0]    rx_state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    assign rx_s = sync[1];
    assign data = shreg;

    // NOTE: synchronizer and edge-detect flops reset to 1 (line idle) so that
    // reset release cannot fake a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= 2'b11;
            rx_d       <= 1'b1;
            rx_state   <= RX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], rx};
            rx_d       <= rx_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_d && !rx_s) begin
                        rx_state <= RX_START;
                        baud_cnt <= '0;
                    end
                end
                RX_START: begin
                    // Re-check half a bit later; a short glitch returns to idle.
                    if (baud_cnt == CNT_HALF) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_s, shreg[7:1]};
                        if (bit_cnt == 3'd7) rx_state <= RX_STOP;
                        else                 bit_cnt  <= bit_cnt + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt   <= '0;
                        rx_state   <= RX_IDLE;
                        byte_valid <= rx_s;
                        frame_err  <= !rx_s;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_ibus_bridge.sv
// UART command bridge: 'W' adr16 dat16 writes and acks with 'K'; 'R' adr16
// reads and returns the 16-bit word high byte first.
module uart_ibus_bridge
    import bridge_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic        tx,
    output logic        ren,
    output logic [15:0] ibus_radr,
    input  logic [15:0] ibus_rdata,
    output logic        wen,
    output logic [15:0] ibus_wadr,
    output logic [15:0] ibus_wdata,
    output logic        busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic        byte_valid;
    logic [7:0]  rx_data;
    logic        frame_err;

    logic [3:0]  state;
    logic        is_read;
    logic [7:0]  adr_hi;
    logic [7:0]  dat_hi;
    logic [15:0] adr;
    logic [2:0]  lat_cnt;
    logic [15:0] rdata_q;
    logic [7:0]  tx_byte;
    logic        tx_load;

    logic [9:0]    tx_frame;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;
    logic          tx_active;
    logic          tx_done;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_valid (byte_valid),
        .data       (rx_data),
        .frame_err  (frame_err)
    );

    assign busy = (state != ST_IDLE);
    assign tx   = tx_frame[0];

    // Idle line is an all-ones frame, so tx comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_frame  <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (tx_load) begin
                tx_frame  <= uart_frame(tx_byte);
                tx_bit    <= '0;
                tx_cnt    <= '0;
                tx_active <= 1'b1;
            end else if (tx_active) begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt   <= '0;
                    tx_frame <= {1'b1, tx_frame[9:1]};
                    if (tx_bit == 4'd9) begin
                        tx_active <= 1'b0;
                        tx_done   <= 1'b1;
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                    end
                end else begin
                    tx_cnt <= tx_cnt + 1'b1;
                end
            end
        end
    end

    // Strobes are set on the transition into ISSUE_* so they coincide with
    // that state for exactly one cycle and default back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            is_read    <= 1'b0;
            adr_hi     <= '0;
            dat_hi     <= '0;
            adr        <= '0;
            lat_cnt    <= '0;
            rdata_q    <= '0;
            tx_byte    <= '0;
            tx_load    <= 1'b0;
            ren        <= 1'b0;
            wen        <= 1'b0;
            ibus_radr  <= '0;
            ibus_wadr  <= '0;
            ibus_wdata <= '0;
        end else begin
            ren     <= 1'b0;
            wen     <= 1'b0;
            tx_load <= 1'b0;
            if (frame_err && state inside {ST_IDLE, ST_ADR_HI, ST_ADR_LO, ST_DAT_HI, ST_DAT_LO}) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (byte_valid && (rx_data == OP_WRITE || rx_data == OP_READ)) begin
                            is_read <= (rx_data == OP_READ);
                            state   <= ST_ADR_HI;
                        end
                    end
                    ST_ADR_HI: begin
                        if (byte_valid) begin
                            adr_hi <= rx_data;
                            state  <= ST_ADR_LO;
                        end
                    end
                    ST_ADR_LO: begin
                        if (byte_valid) begin
                            adr <= {adr_hi, rx_data};
                            if (is_read) begin
                                ren       <= 1'b1;
                                ibus_radr <= {adr_hi, rx_data};
                                state     <= ST_ISSUE_R;
                            end else begin
                                state <= ST_DAT_HI;
                            end
                        end
                    end
                    ST_DAT_HI: begin
                        if (byte_valid) begin
                            dat_hi <= rx_data;
                            state  <= ST_DAT_LO;
                        end
                    end
                    ST_DAT_LO: begin
                        if (byte_valid) begin
                            wen        <= 1'b1;
                            ibus_wadr  <= adr;
                            ibus_wdata <= {dat_hi, rx_data};
                            state      <= ST_ISSUE_W;
                        end
                    end
                    ST_ISSUE_W: begin
                        tx_byte <= ACK_BYTE;
                        tx_load <= 1'b1;
                        state   <= ST_TX_B1;
                    end
                    ST_ISSUE_R: begin
                        lat_cnt <= 3'd1;
                        state   <= ST_WAIT_R;
                    end
                    ST_WAIT_R: begin
                        if (lat_cnt == 3'(RD_LAT)) begin
                            rdata_q <= ibus_rdata;
                            tx_byte <= ibus_rdata[15:8];
                            tx_load <= 1'b1;
                            state   <= ST_TX_B0;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    ST_TX_B0: begin
                        if (tx_done) begin
                            tx_byte <= rdata_q[7:0];
                            tx_load <= 1'b1;
                            state   <= ST_TX_B1;
                        end
                    end
                    ST_TX_B1: begin
                        if (tx_done) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_ibus_bridge.sv
// Directed bench: two bridges (RD_LAT=1 and RD_LAT=3) share one rx line and
// are checked against hand-computed bus cycles and reply bytes.
module tb_uart_ibus_bridge;

    localparam int BD = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;

    always #5 clk = ~clk;

    wire  [1:0]  tx_w, ren_w, wen_w, busy_w;
    wire  [15:0] radr_w [2];
    wire  [15:0] wadr_w [2];
    wire  [15:0] wdata_w [2];
    logic [15:0] rdata_q [2];

    uart_ibus_bridge #(.BAUD_DIV(BD), .RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx_w[0]),
        .ren(ren_w[0]), .ibus_radr(radr_w[0]), .ibus_rdata(rdata_q[0]),
        .wen(wen_w[0]), .ibus_wadr(wadr_w[0]), .ibus_wdata(wdata_w[0]),
        .busy(busy_w[0])
    );

    uart_ibus_bridge #(.BAUD_DIV(BD), .RD_LAT(3)) dut_lat3 (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx_w[1]),
        .ren(ren_w[1]), .ibus_radr(radr_w[1]), .ibus_rdata(rdata_q[1]),
        .wen(wen_w[1]), .ibus_wadr(wadr_w[1]), .ibus_wdata(wdata_w[1]),
        .busy(busy_w[1])
    );

    // Bus model, strobe counters and tx frame decoder, all in one process.
    int          lat_of [2] = '{1, 3};
    logic [15:0] model_data = 16'h0000;
    int          since_ren [2] = '{-1, -1};
    int          wen_n [2] = '{0, 0};
    int          ren_n [2] = '{0, 0};
    int          both_n [2] = '{0, 0};
    logic [15:0] last_wadr [2], last_wdata [2], last_radr [2];
    int          mon_t [2] = '{-1, -1};
    logic [7:0]  mon_sh [2];
    logic [7:0]  tx_bytes [2][64];
    int          tx_n [2] = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ren_w[i]) begin
                since_ren[i] = 0;
                ren_n[i]++;
                last_radr[i] = radr_w[i];
            end else if (since_ren[i] >= 0 && since_ren[i] < 16) begin
                since_ren[i]++;
            end
            rdata_q[i] = (since_ren[i] == lat_of[i]) ? model_data : 16'hDEAD;
            if (wen_w[i]) begin
                wen_n[i]++;
                last_wadr[i]  = wadr_w[i];
                last_wdata[i] = wdata_w[i];
            end
            if (wen_w[i] && ren_w[i]) both_n[i]++;

            if (mon_t[i] < 0) begin
                if (tx_w[i] == 1'b0) mon_t[i] = 0;
            end else begin
                mon_t[i]++;
                if (mon_t[i] == BD / 2 && tx_w[i] != 1'b0) begin
                    mon_t[i] = -1;
                end else if (mon_t[i] > BD / 2 && (mon_t[i] - BD / 2) % BD == 0) begin
                    if (mon_t[i] == BD / 2 + 9 * BD) begin
                        if (tx_n[i] < 64) tx_bytes[i][tx_n[i]] = mon_sh[i];
                        tx_n[i]++;
                        mon_t[i] = -1;
                    end else begin
                        mon_sh[i] = {tx_w[i], mon_sh[i][7:1]};
                    end
                end
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int wen_base [2], ren_base [2], tx_base [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic mark();
        for (int i = 0; i < 2; i++) begin
            wen_base[i] = wen_n[i];
            ren_base[i] = ren_n[i];
            tx_base[i]  = tx_n[i];
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = f[k];
            repeat (BD) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    task automatic wait_tx(input int n);
        int cyc;
        cyc = 0;
        while ((tx_n[0] < tx_base[0] + n || tx_n[1] < tx_base[1] + n) && cyc < 40 * BD * n) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2 * BD) @(negedge clk);
    endtask

    task automatic expect_write(input string tag, input logic [15:0] a, input logic [15:0] d);
        wait_tx(1);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s wen_count[%0d]", tag, i), wen_n[i] - wen_base[i], 1);
            check($sformatf("%s ren_count[%0d]", tag, i), ren_n[i] - ren_base[i], 0);
            check($sformatf("%s wadr[%0d]", tag, i), last_wadr[i], a);
            check($sformatf("%s wdata[%0d]", tag, i), last_wdata[i], d);
            check($sformatf("%s tx_count[%0d]", tag, i), tx_n[i] - tx_base[i], 1);
            check($sformatf("%s ack[%0d]", tag, i), tx_bytes[i][tx_base[i] % 64], 8'h4B);
            check($sformatf("%s busy[%0d]", tag, i), busy_w[i], 1'b0);
        end
    endtask

    task automatic expect_read(input string tag, input logic [15:0] a, input logic [15:0] d);
        wait_tx(2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s ren_count[%0d]", tag, i), ren_n[i] - ren_base[i], 1);
            check($sformatf("%s wen_count[%0d]", tag, i), wen_n[i] - wen_base[i], 0);
            check($sformatf("%s radr[%0d]", tag, i), last_radr[i], a);
            check($sformatf("%s tx_count[%0d]", tag, i), tx_n[i] - tx_base[i], 2);
            check($sformatf("%s byte_hi[%0d]", tag, i), tx_bytes[i][tx_base[i] % 64], d[15:8]);
            check($sformatf("%s byte_lo[%0d]", tag, i), tx_bytes[i][(tx_base[i] + 1) % 64], d[7:0]);
            check($sformatf("%s busy[%0d]", tag, i), busy_w[i], 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset tx[%0d]", i), tx_w[i], 1'b1);
            check($sformatf("reset busy[%0d]", i), busy_w[i], 1'b0);
            check($sformatf("reset wen[%0d]", i), wen_w[i], 1'b0);
            check($sformatf("reset ren[%0d]", i), ren_w[i], 1'b0);
            check($sformatf("reset radr[%0d]", i), radr_w[i], 16'h0000);
            check($sformatf("reset wadr[%0d]", i), wadr_w[i], 16'h0000);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Plain write.
        mark();
        send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
        expect_write("wr1234", 16'h1234, 16'hABCD);

        // Plain read; the RD_LAT=3 bridge only sees good data on the 3rd cycle.
        model_data = 16'hBEEF;
        mark();
        send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        expect_read("rd0010", 16'h0010, 16'hBEEF);

        model_data = 16'h5A3C;
        mark();
        send_byte(8'h52, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h01, 1'b1);
        expect_read("rdFF01", 16'hFF01, 16'h5A3C);

        // Unknown opcode is ignored.
        mark();
        send_byte(8'h41, 1'b1);
        send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1);
        expect_write("junk_op", 16'h0001, 16'h0002);

        // Framing error on the address byte aborts the write.
        model_data = 16'hC3A5;
        mark();
        send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b0);
        send_byte(8'h52, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        expect_read("frame_err", 16'h0000, 16'hC3A5);

        // Reset in the middle of the last data byte.
        mark();
        send_byte(8'h57, 1'b1); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        rx = 1'b1; repeat (BD) @(negedge clk);
        rx = 1'b0; repeat (BD) @(negedge clk);
        for (int i = 0; i < 2; i++)
            check($sformatf("pre_reset busy[%0d]", i), busy_w[i], 1'b1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("mid_reset tx[%0d]", i), tx_w[i], 1'b1);
            check($sformatf("mid_reset wen[%0d]", i), wen_w[i], 1'b0);
            check($sformatf("mid_reset busy[%0d]", i), busy_w[i], 1'b0);
            check($sformatf("mid_reset wadr[%0d]", i), wadr_w[i], 16'h0000);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * BD) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("post_reset wen_count[%0d]", i), wen_n[i] - wen_base[i], 0);
            check($sformatf("post_reset tx_count[%0d]", i), tx_n[i] - tx_base[i], 0);
            check($sformatf("post_reset busy[%0d]", i), busy_w[i], 1'b0);
        end
        mark();
        send_byte(8'h57, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
        expect_write("after_reset", 16'h00AA, 16'h5566);

        for (int i = 0; i < 2; i++)
            check($sformatf("ren_wen_overlap[%0d]", i), both_n[i], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
